// File: rtl/riscv_pipe_pkg.sv
// Shared types and defaults for the RISC-V pipeline registers.
package riscv_pipe_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int RES_SRC_W_DEF  = 2;

    // Default-width view of the EX->MEM payload, fields in port order.
    typedef struct packed {
        logic                      mem_write;
        logic                      reg_write;
        logic [RES_SRC_W_DEF-1:0]  result_src;
        logic [REG_ADDR_W_DEF-1:0] rd;
        logic [XLEN_DEF-1:0]       alu_result;
        logic [XLEN_DEF-1:0]       write_data;
        logic [XLEN_DEF-1:0]       pc_plus_4;
    } ex_mem_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    function automatic logic [1:0] state_occupancy(input pipe_state_e s);
        case (s)
            EMPTY:   return 2'd0;
            ONE:     return 2'd1;
            TWO:     return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush; SKID_EN=0 collapses it
// to a single register with a combinational ready pass-through.
module pipe_skid_buf
    import riscv_pipe_pkg::*;
#(
    parameter int W       = 8,
    parameter int SKID_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    pipe_state_e  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         up_xfer_s;
    logic         dn_xfer_s;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state_occupancy(state_q);
    assign up_xfer_s = in_valid & in_ready;
    assign dn_xfer_s = out_valid & out_ready;

    // Upstream ready: registered-only with a skid entry, else pass-through.
    always_comb begin
        in_ready = 1'b0;
        if (SKID_EN != 0) begin
            in_ready = (state_q != TWO);
        end else begin
            in_ready = !out_valid | out_ready;
        end
    end

    // Next-state and payload steering; flush beats every transfer.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (up_xfer_s) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end else begin
                        state_d = EMPTY;
                    end
                end
                ONE: begin
                    if (up_xfer_s && dn_xfer_s) begin
                        main_d = in_data;
                    end else if (up_xfer_s) begin
                        if (SKID_EN != 0) begin
                            skid_d  = in_data;
                            state_d = TWO;
                        end else begin
                            main_d = in_data;
                        end
                    end else if (dn_xfer_s) begin
                        state_d = EMPTY;
                    end else begin
                        state_d = ONE;
                    end
                end
                TWO: begin
                    if (dn_xfer_s) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end else begin
                        state_d = TWO;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= {W{1'b0}};
            skid_q  <= {W{1'b0}};
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/exe_mem_pipe_reg.sv
// EX->MEM pipeline register with valid/ready stall, flush and optional skid entry.
module exe_mem_pipe_reg
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int RES_SRC_W  = RES_SRC_W_DEF,
    parameter int SKID_EN    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  valid_exe,
    output logic                  ready_exe,
    input  logic                  mem_write_exe,
    input  logic                  reg_write_exe,
    input  logic [RES_SRC_W-1:0]  result_src_exe,
    input  logic [REG_ADDR_W-1:0] rd_exe,
    input  logic [XLEN-1:0]       alu_result_exe,
    input  logic [XLEN-1:0]       write_data_exe,
    input  logic [XLEN-1:0]       pc_plus_4_exe,
    output logic                  valid_m,
    input  logic                  ready_m,
    output logic                  mem_write_m,
    output logic                  reg_write_m,
    output logic [RES_SRC_W-1:0]  result_src_m,
    output logic [REG_ADDR_W-1:0] rd_m,
    output logic [XLEN-1:0]       alu_result_m,
    output logic [XLEN-1:0]       write_data_m,
    output logic [XLEN-1:0]       pc_plus_4_m,
    output logic [1:0]            occupancy
);

    localparam int PW = 2 + RES_SRC_W + REG_ADDR_W + 3 * XLEN;

    logic [PW-1:0] in_pl_s;
    logic [PW-1:0] out_pl_s;
    logic          mem_write_s;
    logic          reg_write_s;

    assign in_pl_s = {mem_write_exe, reg_write_exe, result_src_exe, rd_exe,
                      alu_result_exe, write_data_exe, pc_plus_4_exe};

    pipe_skid_buf #(
        .W       (PW),
        .SKID_EN (SKID_EN)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (valid_exe),
        .in_ready  (ready_exe),
        .in_data   (in_pl_s),
        .out_valid (valid_m),
        .out_ready (ready_m),
        .out_data  (out_pl_s),
        .occupancy (occupancy)
    );

    assign {mem_write_s, reg_write_s, result_src_m, rd_m,
            alu_result_m, write_data_m, pc_plus_4_m} = out_pl_s;

    // A bubble must never write memory or the register file.
    assign mem_write_m = mem_write_s & valid_m;
    assign reg_write_m = reg_write_s & valid_m;

endmodule

// File: doc/exe_mem_pipe_reg.md
Name: exe_mem_pipe_reg

Overview:
Parametrised successor to the fixed EX→MEM pipeline register. It carries the same field set: mem_write, reg_write, result_src, rd, alu_result, write_data and pc_plus_4. New capabilities:
- configurable widths;
- valid/ready handshaking on both sides, so the stage can stall;
- flush, which inserts a bubble;
- an optional 2-entry skid buffer, which keeps upstream ready registered.

It sits between the execute and memory stages of the pipelined RISC-V core.

Parameters:
XLEN, 32, width of alu_result, write_data, pc_plus_4
REG_ADDR_W, 5, width of rd
RES_SRC_W, 2, width of result_src
SKID_EN, 1, 1 = 2-entry skid buffer; 0 = single register with combinational ready pass-through

Ports:
clk  in  1  stage clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held entries, e.g. on branch mispredict
valid_exe  in  1  execute-side payload valid
ready_exe  out  1  stage can accept payload this cycle
mem_write_exe  in  1  store enable
reg_write_exe  in  1  register-file write enable
result_src_exe  in  RES_SRC_W  writeback mux select
rd_exe  in  REG_ADDR_W  destination register
alu_result_exe  in  XLEN  ALU result or address
write_data_exe  in  XLEN  store data
pc_plus_4_exe  in  XLEN  link value
valid_m  out  1  memory-side payload valid
ready_m  in  1  memory stage accepts payload
mem_write_m  out  1  store enable, gated by valid_m
reg_write_m  out  1  register-file write enable, gated by valid_m
result_src_m  out  RES_SRC_W  registered
rd_m  out  REG_ADDR_W  registered
alu_result_m  out  XLEN  registered
write_data_m  out  XLEN  registered
pc_plus_4_m  out  XLEN  registered
occupancy  out  2  entries held (0..2)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state EMPTY; all payload registers 0; valid_m=0; mem_write_m=0; reg_write_m=0; occupancy=0. ready_exe=1 immediately after reset.
- Handshakes:
  - Upstream transfer = valid_exe & ready_exe.
  - Downstream transfer = valid_m & ready_m.
  - Payload must not be sampled when valid_exe=0.
- Latency: an accepted payload appears on the *_m outputs the next cycle (1 cycle). Outputs always come from the main register, never combinationally from inputs.
- Control gating: mem_write_m = stored mem_write & valid_m; reg_write_m likewise. A bubble can never write memory or the register file. Data fields hold their last value while invalid.
- FSM, SKID_EN=1:
  - States EMPTY, ONE, TWO. ready_exe = (state != TWO), driven from the state register only.
  - EMPTY: on upstream transfer, load main and go to ONE.
  - ONE:
    - upstream transfer and downstream transfer: main←in, stay in ONE;
    - upstream transfer and no downstream transfer: skid←in, go to TWO;
    - downstream transfer only: go to EMPTY;
    - neither: hold.
  - TWO: ready_exe=0. On downstream transfer, main←skid and go to ONE; otherwise hold. Ordering is strictly FIFO.
- SKID_EN=0:
  - TWO is unreachable.
  - ready_exe = !valid_m | ready_m (combinational).
  - On upstream transfer, main←in. On downstream transfer without upstream transfer, go to EMPTY.
- Flush:
  - Has priority over every transfer.
  - Next state is EMPTY and valid_m=0; the skid entry is discarded.
  - A payload offered in the flush cycle is dropped, even if ready_exe=1.
  - Any downstream transfer in that same cycle still completes, because its outputs were valid this cycle.
- occupancy: 0 in EMPTY, 1 in ONE, 2 in TWO. It updates with the state.
- Reset mid-operation: immediate return to reset values; in-flight entries are lost.
- Throughput: 1 transfer per cycle sustained when ready_m is held high, for both SKID_EN values.

Decomposition:
- Shared package (riscv_pipe_pkg):
  - default XLEN, REG_ADDR_W, RES_SRC_W constants;
  - packed struct ex_mem_payload_t with the fields in port order;
  - state enum {EMPTY, ONE, TWO}.
- One natural sub-module: pipe_skid_buf. It is a generic payload-width 2-entry valid/ready skid buffer with flush and a SKID_EN parameter.
- exe_mem_pipe_reg then packs the fields, instantiates pipe_skid_buf, and applies the control gating.

Test Plan:
1. Streaming: reset, then ready_m=1 and 4 back-to-back payloads (alu_result 0x10, 0x20, 0x30, 0x40). Expect them on alu_result_m at cycles 1–4 with valid_m=1 and ready_exe held at 1.
2. Stall into skid (SKID_EN=1): hold ready_m=0 and offer A(rd=5) then B(rd=6). Expect occupancy 1→2 and ready_exe=0. Release ready_m: expect rd_m=5 then 6, occupancy 2→1→0.
3. Flush while in TWO with ready_m=0 and flush=1, with valid_exe=1 carrying mem_write_exe=1 offered during the flush cycle. Next cycle: valid_m=0, occupancy=0, mem_write_m=0, reg_write_m=0; the offered payload never appears.
4. Bubble gating: accept a payload with mem_write=1, reg_write=1 and ready_m=1, then valid_exe=0. In the following cycle valid_m=0 and mem_write_m=reg_write_m=0, while write_data_m holds its value.
5. Async reset: assert rst_n=0 mid-cycle while in ONE. Outputs go to 0 without waiting for a clock edge; after release, ready_exe=1 and occupancy=0.
6. SKID_EN=0 with ready_m=0 and valid_m=1: ready_exe=0 in the same cycle. Raise ready_m=1: ready_exe=1 combinationally, and a new payload replaces the old one in a single cycle.
